// File: rtl/palette_lookup_stage_if.sv
// Stream bundle for the palette lookup stage: indexed pixels in, colours out.
// The master modport is the surrounding pipeline, which feeds indices and
// consumes colours. The slave modport is the lookup stage itself.
interface palette_lookup_stage_if #(
  parameter int INDEX_WIDTH = 8
);
  logic [INDEX_WIDTH-1:0] s_idx_tdata;
  logic                   s_idx_tlast;
  logic                   s_idx_tvalid;
  logic                   s_idx_tready;

  logic [15:0]            m_px_tdata;
  logic                   m_px_tlast;
  logic                   m_px_tuser;
  logic                   m_px_tvalid;
  logic                   m_px_tready;

  modport master (
    output s_idx_tdata, s_idx_tlast, s_idx_tvalid,
    input  s_idx_tready,
    input  m_px_tdata, m_px_tlast, m_px_tuser, m_px_tvalid,
    output m_px_tready
  );

  modport slave (
    input  s_idx_tdata, s_idx_tlast, s_idx_tvalid,
    output s_idx_tready,
    output m_px_tdata, m_px_tlast, m_px_tuser, m_px_tvalid,
    input  m_px_tready
  );
endinterface

// File: rtl/palette_lookup_stage.sv
// Streaming palette lookup. Each accepted pixel index, together with the
// palette bank, is turned into a port-B byte address of the colour table. The
// colour returns one cycle later and is queued in a small result FIFO together
// with the delayed tlast and transparency flags. The input is admitted only
// while the FIFO still has room for every lookup in flight, so the stage keeps
// full throughput and never drops a result under backpressure.
module palette_lookup_stage #(
  parameter int OFFSET      = 0,
  parameter int INDEX_WIDTH = 8,
  parameter int BANK_WIDTH  = 4,
  parameter int FIFO_DEPTH  = 3
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  palette_lookup_stage_if.slave axis,
  input  logic [BANK_WIDTH-1:0] bank,
  input  logic                  transparent_en,
  output logic [15:0]           portb_address,
  input  logic [15:0]           portb_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [15:0]      OFFSET_ADDR = 16'(OFFSET);
  localparam logic [CNT_W:0]   DEPTH_LIM   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [15:0] colour;
    logic        last;
    logic        user;
  } entry_t;

  logic [CNT_W-1:0] fifo_count;
  logic             inflight;
  logic [CNT_W:0]   outstanding;
  logic             accept;
  logic             push;
  logic             pop;
  logic             out_valid;

  logic [15:0]      lookup_key;
  logic [15:0]      addr_issue;
  logic [15:0]      addr_q;

  logic             tlast_q;
  logic             tuser_q;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  entry_t           head;

  // Admission control: room is reserved for the lookup still in flight. The
  // ready signal depends only on registered state and aresetn, never on
  // m_px_tready.
  always_comb begin
    outstanding       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    axis.s_idx_tready = aresetn && (outstanding < DEPTH_LIM);
    accept            = axis.s_idx_tvalid && axis.s_idx_tready;
  end

  // Byte address of the palette entry selected by {bank, index}.
  always_comb begin
    lookup_key    = 16'({bank, axis.s_idx_tdata});
    addr_issue    = OFFSET_ADDR + (lookup_key << 1);
    portb_address = accept ? addr_issue : addr_q;
  end

  // Hold the last issued address on cycles without an accept.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q <= OFFSET_ADDR;
    end else if (accept) begin
      addr_q <= addr_issue;
    end
  end

  // Delay the sideband by one cycle so it lines up with the returning colour.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        tlast_q <= axis.s_idx_tlast;
        tuser_q <= transparent_en && (axis.s_idx_tdata == '0);
      end
    end
  end

  // FIFO handshakes: a push always fits because admission reserved its slot.
  always_comb begin
    push      = inflight;
    out_valid = (fifo_count != '0);
    pop       = out_valid && axis.m_px_tready;
  end

  // Result FIFO storage and pointers. Pointers wrap explicitly so that depths
  // which are not a power of two work.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{colour: portb_data, last: tlast_q, user: tuser_q};
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy tracking. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fifo_count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Present the FIFO head. The data is forced to zero while empty, so the
  // outputs are clean during and right after reset.
  always_comb begin
    head             = mem[rd_ptr];
    axis.m_px_tvalid = out_valid;
    axis.m_px_tdata  = out_valid ? head.colour : '0;
    axis.m_px_tlast  = out_valid && head.last;
    axis.m_px_tuser  = out_valid && head.user;
  end

endmodule

// File: tb/tb_palette_lookup_stage.sv
// Self-checking bench for palette_lookup_stage. Stimulus pushes the expected
// colour, tlast and tuser into a scoreboard queue when a pixel is accepted. A
// separate monitor pops the queue on each output transfer and compares.
module tb_palette_lookup_stage;

  localparam int OFFSET = 0;

  typedef struct packed {
    logic [15:0] colour;
    logic        last;
    logic        user;
  } exp_t;

  logic        aclk;
  logic        aresetn;
  logic [3:0]  bank;
  logic        transparent_en;
  logic [15:0] portb_address;
  logic [15:0] portb_data;

  palette_lookup_stage_if #(.INDEX_WIDTH(8)) axis ();

  palette_lookup_stage #(
    .OFFSET     (OFFSET),
    .INDEX_WIDTH(8),
    .BANK_WIDTH (4),
    .FIFO_DEPTH (3)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .axis          (axis),
    .bank          (bank),
    .transparent_en(transparent_en),
    .portb_address (portb_address),
    .portb_data    (portb_data)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   pops  = 0;
  int   pop_cyc [0:1023];
  int   accept_cyc = 0;
  exp_t sb [$];

  logic [15:0] pal [4096];

  function automatic logic [15:0] pal_init(int unsigned k);
    if (k == 5)      return 16'h1234;
    if (k == 'h210)  return 16'hBEEF;
    return 16'hA000 | 16'(k & 'hFFF);
  endfunction

  function automatic logic [15:0] addr_of(logic [3:0] bk, logic [7:0] idx);
    logic [15:0] key;
    key = {4'b0, bk, idx};
    return 16'(OFFSET) + (key << 1);
  endfunction

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    forever begin
      @(posedge aclk);
      cyc++;
    end
  end

  // Colour table port B: one cycle of read latency.
  initial begin
    for (int k = 0; k < 4096; k++) pal[k] = pal_init(k);
    portb_data = '0;
    forever begin
      @(posedge aclk);
      portb_data <= pal[portb_address[12:1]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on each transfer, plus output stability under stall.
  initial begin
    logic        stall_prev;
    logic [17:0] prev;
    exp_t        e;
    stall_prev = 1'b0;
    prev       = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          n_cmp++;
          if (!axis.m_px_tvalid ||
              {axis.m_px_tdata, axis.m_px_tlast, axis.m_px_tuser} !== prev) begin
            n_bad++;
            $display("FAIL stall_stable: got v=%0b %h expected v=1 %h",
                     axis.m_px_tvalid, {axis.m_px_tdata, axis.m_px_tlast, axis.m_px_tuser}, prev);
          end
        end
        if (axis.m_px_tvalid && axis.m_px_tready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got colour 0x%0h expected no output", axis.m_px_tdata);
          end else begin
            e = sb.pop_front();
            if (axis.m_px_tdata !== e.colour || axis.m_px_tlast !== e.last ||
                axis.m_px_tuser !== e.user) begin
              n_bad++;
              $display("FAIL px_out: got colour=0x%0h last=%0b user=%0b expected colour=0x%0h last=%0b user=%0b",
                       axis.m_px_tdata, axis.m_px_tlast, axis.m_px_tuser, e.colour, e.last, e.user);
            end
          end
          if (pops < 1024) pop_cyc[pops] = cyc;
          pops++;
        end
        stall_prev = axis.m_px_tvalid && !axis.m_px_tready;
        prev       = {axis.m_px_tdata, axis.m_px_tlast, axis.m_px_tuser};
      end
    end
  end

  // Issue one pixel; called just after a rising edge.
  task automatic send(input logic [7:0] idx, input logic [3:0] bk, input logic ten,
                      input logic last, input logic [15:0] exp_addr,
                      input logic [15:0] exp_col, input logic exp_user);
    axis.s_idx_tdata  = idx;
    axis.s_idx_tlast  = last;
    bank              = bk;
    transparent_en    = ten;
    axis.s_idx_tvalid = 1'b1;
    for (int w = 0; w < 200; w++) begin
      @(negedge aclk);
      if (axis.s_idx_tready) begin
        chk("portb_address", 32'(portb_address), 32'(exp_addr));
        sb.push_back('{colour: exp_col, last: last, user: exp_user});
        accept_cyc = cyc;
        @(posedge aclk);
        #1;
        axis.s_idx_tvalid = 1'b0;
        return;
      end
      @(posedge aclk);
      #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: got no s_idx_tready expected accept within 200 cycles");
    axis.s_idx_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int w = 0; w < 300; w++) begin
      if (sb.size() == 0) return;
      @(posedge aclk);
      #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
  endtask

  task automatic send_line(output int first_acc);
    first_acc = 0;
    for (int i = 0; i < 64; i++) begin
      send(8'(i), 4'h0, 1'b0, (i == 63), 16'(i * 2), pal_init(i), 1'b0);
      if (i == 0) first_acc = accept_cyc;
    end
  endtask

  initial begin
    int base;
    int first_acc;
    int v_seen;

    aresetn           = 1'b0;
    bank              = '0;
    transparent_en    = 1'b0;
    axis.s_idx_tdata  = '0;
    axis.s_idx_tlast  = 1'b0;
    axis.s_idx_tvalid = 1'b0;
    axis.m_px_tready  = 1'b0;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", 32'(axis.m_px_tvalid), 0);
    chk("rst_tdata", 32'(axis.m_px_tdata), 0);
    chk("rst_tlast_tuser", 32'({axis.m_px_tlast, axis.m_px_tuser}), 0);
    chk("rst_tready", 32'(axis.s_idx_tready), 0);
    chk("rst_addr", 32'(portb_address), 32'(OFFSET));
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_tready", 32'(axis.s_idx_tready), 1);
    @(posedge aclk);
    #1;

    // Single pixel, latency
    axis.m_px_tready = 1'b1;
    send(8'd5, 4'h0, 1'b0, 1'b0, 16'h000A, 16'h1234, 1'b0);
    @(negedge aclk);
    chk("lat_n1_tvalid", 32'(axis.m_px_tvalid), 0);
    @(negedge aclk);
    chk("lat_n2_tvalid", 32'(axis.m_px_tvalid), 1);
    chk("lat_n2_tdata", 32'(axis.m_px_tdata), 32'h1234);
    @(posedge aclk);
    #1;

    // Bank select
    send(8'h10, 4'h2, 1'b0, 1'b0, 16'h0420, 16'hBEEF, 1'b0);
    drain();

    // 64-pixel line, no backpressure
    base = pops;
    send_line(first_acc);
    drain();
    chk("line_count", 32'(pops - base), 64);
    chk("line_first_lat", 32'(pop_cyc[base] - first_acc), 2);
    chk("line_span", 32'(pop_cyc[base + 63] - pop_cyc[base]), 63);

    // Same line with a 10-cycle stall mid-stream
    base = pops;
    fork
      send_line(first_acc);
      begin
        repeat (20) @(posedge aclk);
        #1;
        axis.m_px_tready = 1'b0;
        repeat (10) @(negedge aclk);
        chk("stall_tready", 32'(axis.s_idx_tready), 0);
        chk("stall_outstanding", 32'(sb.size()), 3);
        @(posedge aclk);
        #1;
        axis.m_px_tready = 1'b1;
        @(negedge aclk);
        chk("release_tready_same", 32'(axis.s_idx_tready), 0);
        @(negedge aclk);
        chk("release_tready_next", 32'(axis.s_idx_tready), 1);
      end
    join
    drain();
    chk("stall_line_count", 32'(pops - base), 64);

    // Transparency, with per-pixel sampling of transparent_en
    send(8'd0, 4'h0, 1'b1, 1'b0, 16'h0000, 16'hA000, 1'b1);
    send(8'd1, 4'h0, 1'b1, 1'b0, 16'h0002, 16'hA001, 1'b0);
    send(8'd0, 4'h0, 1'b0, 1'b1, 16'h0000, 16'hA000, 1'b0);
    drain();

    // Reset with two pixels buffered and one in flight
    axis.m_px_tready = 1'b0;
    send(8'd7, 4'h1, 1'b0, 1'b0, addr_of(4'h1, 8'd7), 16'hA107, 1'b0);
    send(8'd8, 4'h1, 1'b0, 1'b0, addr_of(4'h1, 8'd8), 16'hA108, 1'b0);
    send(8'd9, 4'h1, 1'b0, 1'b0, addr_of(4'h1, 8'd9), 16'hA109, 1'b0);
    chk("pre_rst_tvalid", 32'(axis.m_px_tvalid), 1);
    chk("pre_rst_tready", 32'(axis.s_idx_tready), 0);
    #1;
    aresetn = 1'b0;
    #1;
    chk("async_rst_tvalid", 32'(axis.m_px_tvalid), 0);
    chk("async_rst_tready", 32'(axis.s_idx_tready), 0);
    chk("async_rst_addr", 32'(portb_address), 32'(OFFSET));
    sb.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    axis.m_px_tready = 1'b1;
    v_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge aclk);
      if (axis.m_px_tvalid) v_seen++;
    end
    chk("post_rst_no_stale", 32'(v_seen), 0);
    chk("post_rst_tready2", 32'(axis.s_idx_tready), 1);
    @(posedge aclk);
    #1;
    base = pops;
    send(8'h21, 4'h3, 1'b0, 1'b1, 16'h0642, 16'hA321, 1'b0);
    drain();
    chk("post_rst_one_px", 32'(pops - base), 1);

    repeat (3) @(posedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/palette_lookup_stage.md
# palette_lookup_stage

Streaming palette-lookup stage that converts indexed pixels into 16-bit colours using the read-only port B of the AXI-Lite colour table. It sits directly downstream of the indexed-pixel source (framebuffer/tile fetch) and upstream of the scan-out/blend stage. It drives the colour table's `portb_address` and consumes `portb_data`, which has one cycle of latency. It buffers results so that full throughput is kept under downstream backpressure.

## Interface
- `OFFSET`, default 0: byte base address of the colour table; must equal the colour table's own `OFFSET`.
- `INDEX_WIDTH`, default 8: pixel index width.
- `BANK_WIDTH`, default 4: palette bank select width; `INDEX_WIDTH + BANK_WIDTH + 1` ≤ 16.
- `FIFO_DEPTH`, default 3: result buffer entries; minimum 3.

Ports:
- `aclk`  in  1  the single clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `s_idx_tdata`  in  INDEX_WIDTH  pixel index.
- `s_idx_tlast`  in  1  end-of-line marker.
- `s_idx_tvalid`  in  1  input valid.
- `s_idx_tready`  out  1  input ready.
- `bank`  in  BANK_WIDTH  palette bank, sampled per accepted pixel.
- `transparent_en`  in  1  index 0 is treated as transparent; sampled per accepted pixel.
- `portb_address`  out  16  byte address to the colour table port B.
- `portb_data`  in  16  colour from port B, valid one cycle after the address.
- `m_px_tdata`  out  16  colour.
- `m_px_tlast`  out  1  forwarded `s_idx_tlast`.
- `m_px_tuser`  out  1  transparent flag.
- `m_px_tvalid`  out  1  output valid.
- `m_px_tready`  in  1  output ready.

## Operation
- Accept occurs when `s_idx_tvalid && s_idx_tready`.
- `s_idx_tready = aresetn && (fifo_count + inflight) < FIFO_DEPTH`.
  - `inflight` is a 1-bit register set on accept.
  - `fifo_count` is the buffer occupancy.
  - There is no combinational path from `m_px_tready`.
- Address on the accept cycle (combinational from the inputs): `portb_address = OFFSET + ({bank, s_idx_tdata} << 1)`, truncated to 16 bits.
- On non-accept cycles `portb_address` holds the last issued value in a register.
- Sideband captured at accept and delayed one cycle alongside the lookup:
  - `s_idx_tlast`.
  - `tuser = transparent_en && (s_idx_tdata == 0)`.
- Cycle after accept: `{portb_data, tlast, tuser}` is pushed into the FIFO. `inflight` clears unless a new accept happens in the same cycle.
- FIFO output drives `m_px_*`. A pop occurs on `m_px_tvalid && m_px_tready`. Push and pop in the same cycle leave `fifo_count` unchanged.
- Strict order is kept: no pixel is dropped or duplicated.
- Transparent pixels still carry the looked-up colour in `m_px_tdata`.
- There is no coherence with AXI writes to the colour table. The colour is the memory content at the port-B sampling edge.

## Timing
- Reset values (async assert, all outputs):
  - `m_px_tvalid=0`, `m_px_tdata=0`, `m_px_tlast=0`, `m_px_tuser=0`.
  - `s_idx_tready=0`.
  - `portb_address=OFFSET[15:0]`.
  - `fifo_count=0`, `inflight=0`.
- First cycle after release: `s_idx_tready=1`.
- Latency: an accept in cycle N gives a push at the end of N+1 and `m_px_tvalid=1` in N+2 (when the FIFO was empty).
- Throughput: 1 pixel/cycle sustained with `m_px_tready=1`.
- Backpressure: with `m_px_tready=0`, at most `FIFO_DEPTH` pixels are accepted before `s_idx_tready` drops. Ready returns the cycle after the first pop.
- `m_px_*` is stable while `m_px_tvalid && !m_px_tready`.
- Reset mid-operation discards the FIFO contents and any in-flight lookup. No stale pixel appears after release.
- Bank or `transparent_en` changes take effect from the next accepted pixel. Pixels already accepted are unaffected.

## Test plan
- Single pixel, index 5, bank 0, OFFSET 0, palette[5]=0x1234 → `portb_address=0x000A` on the accept cycle; `m_px_tdata=0x1234`, tuser=0, at N+2.
- Bank 2, index 0x10, INDEX_WIDTH 8 → `portb_address=0x0420`; output = palette[0x210].
- 64-pixel line, indices 0..63, tlast on the last pixel, `m_px_tready=1` → 64 outputs on consecutive cycles starting N+2, in order, tlast only on the 64th.
- Same line with `m_px_tready` low for 10 cycles mid-stream → `s_idx_tready` drops after 3 outstanding pixels; after release all 64 arrive in order with no loss or duplication.
- `transparent_en=1`, index 0 → tuser=1. Index 1 → tuser=0. `transparent_en=0`, index 0 → tuser=0.
- Assert `aresetn` with 2 pixels buffered and 1 in flight → `m_px_tvalid=0` immediately; after release there is no output until a new pixel is accepted, and `s_idx_tready=1`.
